// File: rtl/ecap5_dmem_if.sv
// Wishbone B4 pipelined bus between the ecap5_dproc master and the data memory.
interface ecap5_dmem_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic        wb_cyc_i;
  logic        wb_stall_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );
endinterface

// File: rtl/ecap5_dmem.sv
// Wishbone pipelined slave memory: fixed-latency in-order responses,
// byte-lane writes, outstanding-request limit signalled through stall.
module ecap5_dmem #(
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ecap5_dmem_if.slave  wb
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = 4;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0]              idx;
  logic                       acc;
  logic [31:0]                rdat;
  logic [LATENCY-1:0]         vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0][31:0]   dat_pipe_q, dat_pipe_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       unused_adr;

  // Address bits outside the word index are don't-care (addresses wrap).
  assign unused_adr = ^{wb.wb_adr_i[31:AW+2], wb.wb_adr_i[1:0]};
  assign idx        = wb.wb_adr_i[AW+1:2];
  assign rdat       = mem[idx];

  // The last pipe stage is the registered response itself.
  assign wb.wb_ack_o   = vld_pipe_q[LATENCY-1];
  assign wb.wb_dat_o   = dat_pipe_q[LATENCY-1];
  // Stall only from registered state; an ack this cycle frees a slot.
  assign wb.wb_stall_o = (cnt_q == CW'(MAX_OUTSTANDING)) & ~vld_pipe_q[LATENCY-1];
  assign acc           = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_stall_o;

  // Byte-lane write at the accept edge; memory is never reset.
  always_ff @(posedge clk_i) begin
    if (acc && wb.wb_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.wb_sel_i[b]) mem[idx][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
      end
    end
  end

  // Next-state for response pipe and outstanding counter; cyc low flushes.
  always_comb begin
    vld_pipe_d = '0;
    dat_pipe_d = '0;
    cnt_d      = cnt_q + CW'(acc) - CW'(vld_pipe_q[LATENCY-1]);
    for (int i = LATENCY - 1; i > 0; i--) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      dat_pipe_d[i] = dat_pipe_q[i-1];
    end
    vld_pipe_d[0] = acc;
    // Writes ack with zero data; idle slots carry zero so dat_o is 0 off-ack.
    dat_pipe_d[0] = (acc && !wb.wb_we_i) ? rdat : 32'h0;
    if (!wb.wb_cyc_i) begin
      vld_pipe_d = '0;
      dat_pipe_d = '0;
      cnt_d      = '0;
    end
  end

  // Pipe and counter state; reset drops everything in flight at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ecap5_dmem.sv
// Scoreboard bench: two memories (MAX_OUTSTANDING 1 and 2, LATENCY 2) share
// stimulus wires; a driver pushes expected {data, ack cycle} on accept and a
// negedge monitor pops and compares every ack.
module tb_ecap5_dmem;
  localparam int L = 2;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, stb = 1'b0, tgt = 1'b0, cyc0 = 1'b0, cyc1 = 1'b0;
  int          cyc_n = 0;
  int          vecs = 0, misc = 0;
  exp_t        q0[$], q1[$];

  ecap5_dmem_if bus0();
  ecap5_dmem_if bus1();

  assign bus0.wb_adr_i = adr;  assign bus1.wb_adr_i = adr;
  assign bus0.wb_dat_i = wdat; assign bus1.wb_dat_i = wdat;
  assign bus0.wb_sel_i = sel;  assign bus1.wb_sel_i = sel;
  assign bus0.wb_we_i  = we;   assign bus1.wb_we_i  = we;
  assign bus0.wb_stb_i = stb & ~tgt;
  assign bus1.wb_stb_i = stb & tgt;
  assign bus0.wb_cyc_i = cyc0;
  assign bus1.wb_cyc_i = cyc1;

  ecap5_dmem #(.DEPTH_WORDS(1024), .LATENCY(L), .MAX_OUTSTANDING(1)) dut (
    .clk_i(clk), .rst_i(rst), .wb(bus0));
  ecap5_dmem #(.DEPTH_WORDS(1024), .LATENCY(L), .MAX_OUTSTANDING(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .wb(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one request and hold it until accepted; stb stays high afterwards
  // so consecutive calls form back-to-back traffic. exp_stall<0 skips the
  // first-sample stall check.
  task automatic req(input logic t, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp, input bit push, input int exp_stall);
    bit   done = 0;
    logic st;
    exp_t e;
    tgt = t; we = w; adr = a; wdat = d; sel = s; stb = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      st = t ? bus1.wb_stall_o : bus0.wb_stall_o;
      if (n == 0 && exp_stall >= 0) chk("stall_at_issue", {31'b0, st}, exp_stall[31:0]);
      if (!st) begin
        if (push) begin
          e.d = exp; e.c = cyc_n + L;
          if (t) q1.push_back(e); else q0.push_back(e);
        end
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      vecs++; misc++;
      $display("FAIL accept_timeout: got stalled expected accept adr=%h", a);
    end
  endtask

  task automatic idle();
    stb = 1'b0; we = 1'b0;
  endtask

  // Monitor: every ack pops one expectation; dat_o must be 0 off-ack.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus0.wb_ack_o) begin
        if (q0.size() == 0) begin
          vecs++; misc++;
          $display("FAIL dut0_ack: got unexpected ack expected none, cycle %0d", cyc_n);
        end else begin
          e = q0.pop_front();
          chk("dut0_data", bus0.wb_dat_o, e.d);
          chk("dut0_ack_cycle", cyc_n, e.c);
        end
      end else chk("dut0_dat_idle", bus0.wb_dat_o, 32'h0);
      if (bus1.wb_ack_o) begin
        if (q1.size() == 0) begin
          vecs++; misc++;
          $display("FAIL dut1_ack: got unexpected ack expected none, cycle %0d", cyc_n);
        end else begin
          e = q1.pop_front();
          chk("dut1_data", bus1.wb_dat_o, e.d);
          chk("dut1_ack_cycle", cyc_n, e.c);
        end
      end else chk("dut1_dat_idle", bus1.wb_dat_o, 32'h0);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    repeat (10) begin
      @(negedge clk);
      chk("idle_ack", {31'b0, bus0.wb_ack_o}, 32'h0);
      chk("idle_stall", {31'b0, bus0.wb_stall_o}, 32'h0);
      chk("idle_dat", bus0.wb_dat_o, 32'h0);
    end
    @(posedge clk); #1;
    cyc0 = 1'b1; cyc1 = 1'b1;

    // Full-word write then read; read stalls once behind the write
    req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1, 0);
    req(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1, 1);
    idle();
    // Byte-lane writes, including an empty select
    req(0, 1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1, -1);
    req(0, 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 1, 1);
    req(0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1, 1);
    req(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1, 1);
    req(0, 1, 32'h12, 32'h12345678, 4'b1100, 32'h0, 1, 1);
    req(0, 0, 32'h13, 32'h0, 4'h1, 32'h1234BEAA, 1, 1);
    // Back-to-back traffic at MAX_OUTSTANDING=1: stall after every accept
    for (int i = 0; i < 4; i++)
      req(0, 1, 32'h20 + 4*i, 32'h10000000 + i, 4'hF, 32'h0, 1, 1);
    for (int i = 0; i < 4; i++)
      req(0, 0, 32'h20 + 4*i, 32'h0, 4'hF, 32'h10000000 + i, 1, 1);
    idle();

    // MAX_OUTSTANDING=2: never stalls, address aliasing and wrap
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++)
      req(1, 1, 32'h1000 + 4*i, 32'hA5000000 + i, 4'hF, 32'h0, 1, 0);
    req(1, 1, 32'h1000, 32'h0BADF00D, 4'hF, 32'h0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, x;
      a = (i == 0) ? 32'h2000 : (i == 1) ? 32'hFFFFF004 : 32'h1000 + 4*i;
      x = (i == 0) ? 32'h0BADF00D : 32'hA5000000 + i;
      req(1, 0, a, 32'h0, 4'h0, x, 1, 0);
    end
    idle();
    repeat (4) @(posedge clk); #1;

    // cyc drop with one read in flight: no ack, count cleared
    req(0, 0, 32'h10, 32'h0, 4'hF, 32'h0, 0, 0);
    idle(); cyc0 = 1'b0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("cycdrop_ack", {31'b0, bus0.wb_ack_o}, 32'h0);
      chk("cycdrop_stall", {31'b0, bus0.wb_stall_o}, 32'h0);
    end
    @(posedge clk); #1;
    cyc0 = 1'b1;

    // Reset while an ack is showing: ack falls without a clock edge
    req(0, 0, 32'h10, 32'h0, 4'hF, 32'h0, 0, 0);
    idle();
    @(posedge clk); #1;
    chk("pre_rst_ack", {31'b0, bus0.wb_ack_o}, 32'h1);
    chk("pre_rst_dat", bus0.wb_dat_o, 32'h1234BEAA);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ack", {31'b0, bus0.wb_ack_o}, 32'h0);
    chk("async_rst_dat", bus0.wb_dat_o, 32'h0);
    chk("async_rst_stall", {31'b0, bus0.wb_stall_o}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    // Memory survives reset
    req(0, 0, 32'h10, 32'h0, 4'hF, 32'h1234BEAA, 1, 0);
    idle();

    repeat (6) @(posedge clk);
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
    $finish;
  end
endmodule
